// File: rtl/cid_pkg.sv
// ---------------------------------------------------------------------------
// cid_pkg
// Shared definitions for the instruction store: the default RAM geometry
// used by the loader, the RAM and the program counter, the padding code
// written past the end of a program, and the loader state encoding.
// ---------------------------------------------------------------------------
package cid_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 4;
   localparam logic [3:0] NOP_CODE_DEF = 4'h0;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PAD,
      DONE
   } load_state_t;

endpackage

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Write-side counterpart of the instruction store's fetch path. Takes a
// program as a valid/ready stream of instruction words, writes each word
// into instruction RAM at an auto-incrementing address, pads the rest of the
// RAM with NOP_CODE and then raises run_en so the fetch side starts only on
// a completely written program.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   load_req  single-cycle request to start a new load (IDLE or DONE only)
//   in_valid  source presents a word on in_data
//   in_data   instruction word
//   in_last   marks in_data as the final program word
//   in_ready  combinational; high exactly while loading words
//   wr_en     RAM write strobe (registered)
//   wr_addr   RAM write address (registered)
//   wr_data   RAM write data (registered)
//   run_en    fetch side may run (registered)
//   busy      load or pad in progress (registered)
//   prog_len  number of program words accepted
//   overflow  sticky; the program did not fit in the RAM
// ---------------------------------------------------------------------------
module program_loader
   import cid_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter logic [DATA_W-1:0] NOP_CODE = DATA_W'(NOP_CODE_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              run_en,
   output logic              busy,
   output logic [ADDR_W:0]   prog_len,
   output logic              overflow
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

   load_state_t state;
   load_state_t next_state;

   // ptr carries one extra bit so it can reach DEPTH after the final write
   // without wrapping back onto address 0.
   logic [ADDR_W:0]   ptr;
   logic [ADDR_W:0]   ptr_nxt;
   logic              wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [DATA_W-1:0] wr_data_nxt;
   logic              run_en_nxt;
   logic              busy_nxt;
   logic [ADDR_W:0]   prog_len_nxt;
   logic              overflow_nxt;
   logic              transfer;
   logic              at_end;

   assign at_end = (ptr == LAST_PTR);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A word that lands on the last RAM address always
   // ends the load, whether it was marked last (exact fit) or not (overflow).
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (load_req) next_state = LOAD;
         end
         LOAD: begin
            if (transfer) begin
               if (at_end)       next_state = DONE;
               else if (in_last) next_state = PAD;
            end
         end
         PAD: begin
            if (at_end) next_state = DONE;
         end
         DONE: begin
            if (load_req) next_state = LOAD;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic: the combinational ready plus the next values of every
   // registered output. run_en is only raised from inside DONE, so it comes
   // up one cycle after the final write strobe, once that write has landed.
   always_comb begin
      in_ready     = (state == LOAD);
      transfer     = in_valid && (state == LOAD);
      ptr_nxt      = ptr;
      wr_en_nxt    = 1'b0;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      run_en_nxt   = run_en;
      prog_len_nxt = prog_len;
      overflow_nxt = overflow;
      case (state)
         IDLE: begin
            if (load_req) begin
               ptr_nxt      = '0;
               prog_len_nxt = '0;
               overflow_nxt = 1'b0;
               run_en_nxt   = 1'b0;
            end
         end
         LOAD: begin
            if (transfer) begin
               wr_en_nxt    = 1'b1;
               wr_addr_nxt  = ptr[ADDR_W-1:0];
               wr_data_nxt  = in_data;
               ptr_nxt      = ptr + 1'b1;
               prog_len_nxt = prog_len + 1'b1;
               if (at_end && !in_last) overflow_nxt = 1'b1;
            end
         end
         PAD: begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = ptr[ADDR_W-1:0];
            wr_data_nxt = NOP_CODE;
            ptr_nxt     = ptr + 1'b1;
         end
         DONE: begin
            run_en_nxt = 1'b1;
            if (load_req) begin
               run_en_nxt   = 1'b0;
               ptr_nxt      = '0;
               prog_len_nxt = '0;
               overflow_nxt = 1'b0;
            end
         end
         default: ;
      endcase
      busy_nxt = (next_state == LOAD) || (next_state == PAD);
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         run_en   <= 1'b0;
         busy     <= 1'b0;
         prog_len <= '0;
         overflow <= 1'b0;
      end else begin
         ptr      <= ptr_nxt;
         wr_en    <= wr_en_nxt;
         wr_addr  <= wr_addr_nxt;
         wr_data  <= wr_data_nxt;
         run_en   <= run_en_nxt;
         busy     <= busy_nxt;
         prog_len <= prog_len_nxt;
         overflow <= overflow_nxt;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. Each load computes the complete
// expected RAM write sequence (program words followed by NOP padding up to
// the last address) and pushes it into a queue; a negedge monitor pops and
// compares every write strobe the loader produces.
// ---------------------------------------------------------------------------
module tb_program_loader;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 4;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] NOP = 4'h0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load_req = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              run_en;
   logic              busy;
   logic [ADDR_W:0]   prog_len;
   logic              overflow;

   int checks = 0;
   int errors = 0;

   wr_t               exp_q[$];
   logic [DATA_W-1:0] prog_q[$];

   program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_CODE(NOP)) dut (
      .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .run_en(run_en),
      .busy(busy), .prog_len(prog_len), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // One comparison: counts it and reports any mismatch.
   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Monitor: every write strobe must match the next expected write, and
   // run_en must never be high while a write is still in flight.
   always @(negedge clk) begin
      if (!rst && wr_en) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_write", 1, 0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_output("wr_addr", int'(wr_addr), int'(e.addr));
            check_output("wr_data", int'(wr_data), int'(e.data));
            check_output("run_en_during_write", int'(run_en), 0);
         end
      end
   end

   // Hold reset for a few cycles and confirm every output is cleared.
   task automatic do_reset(input int cycles);
      rst = 1'b1;
      load_req = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      repeat (cycles) @(posedge clk);
      #1;
      check_output("rst_in_ready", int'(in_ready), 0);
      check_output("rst_wr_en", int'(wr_en), 0);
      check_output("rst_wr_addr", int'(wr_addr), 0);
      check_output("rst_wr_data", int'(wr_data), 0);
      check_output("rst_run_en", int'(run_en), 0);
      check_output("rst_busy", int'(busy), 0);
      check_output("rst_prog_len", int'(prog_len), 0);
      check_output("rst_overflow", int'(overflow), 0);
      rst = 1'b0;
   endtask

   // Issue load_req for one cycle; afterwards the loader must be loading
   // with run_en down and its status cleared.
   task automatic pulse_load();
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      check_output("load_run_en", int'(run_en), 0);
      check_output("load_busy", int'(busy), 1);
      check_output("load_in_ready", int'(in_ready), 1);
      check_output("load_prog_len", int'(prog_len), 0);
      check_output("load_overflow", int'(overflow), 0);
   endtask

   // Offer one word until it is accepted or max_wait cycles pass.
   task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic last,
                                 input int max_wait, output bit accepted);
      bit rdy;
      accepted = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int c = 0; c < max_wait && !accepted; c++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         accepted = rdy;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Load the program in prog_q. has_last marks the final word as last;
   // without it the program is expected to overflow the RAM.
   task automatic run_program(input bit has_last, input int stall_max);
      int  n;
      int  exp_len;
      bit  acc;
      bit  seen;
      wr_t w;
      n = prog_q.size();
      exp_len = (n < DEPTH) ? n : DEPTH;
      for (int a = 0; a < DEPTH; a++) begin
         w.addr = ADDR_W'(a);
         w.data = (a < exp_len) ? prog_q[a] : NOP;
         exp_q.push_back(w);
      end
      pulse_load();
      for (int i = 0; i < n; i++) begin
         int stall;
         stall = $urandom_range(0, stall_max);
         repeat (stall) @(posedge clk);
         #1;
         if (i < DEPTH) begin
            apply_stimulus(prog_q[i], has_last && (i == n - 1), 50, acc);
            check_output("word_accepted", int'(acc), 1);
         end else begin
            apply_stimulus(prog_q[i], 1'b0, 20, acc);
            check_output("extra_word_refused", int'(acc), 0);
         end
      end
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         seen = run_en;
      end
      check_output("run_en_rose", int'(seen), 1);
      check_output("writes_outstanding", exp_q.size(), 0);
      check_output("done_prog_len", int'(prog_len), exp_len);
      check_output("done_overflow", int'(overflow), has_last ? 0 : 1);
      check_output("done_busy", int'(busy), 0);
      check_output("done_in_ready", int'(in_ready), 0);
      check_output("done_wr_en", int'(wr_en), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      do_reset(2);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_output("idle_wr_en", int'(wr_en), 0);
      end

      // Short program, no stalls.
      prog_q = '{4'h3, 4'h7, 4'hA};
      run_program(1'b1, 0);

      // Same program with stalls between words (reload from DONE).
      run_program(1'b1, 2);

      // Exact fit: 16 words 0..F.
      prog_q.delete();
      for (int i = 0; i < DEPTH; i++) prog_q.push_back(DATA_W'(i));
      run_program(1'b1, 1);

      // Overflow: 17 words, none marked last.
      prog_q.delete();
      for (int i = 0; i < DEPTH + 1; i++) prog_q.push_back(DATA_W'($urandom));
      run_program(1'b0, 1);

      // Reset in the middle of a load, then a full reload.
      begin
         wr_t w;
         bit  acc;
         pulse_load();
         for (int i = 0; i < 5; i++) begin
            w.addr = ADDR_W'(i);
            w.data = DATA_W'(i + 9);
            exp_q.push_back(w);
            apply_stimulus(DATA_W'(i + 9), 1'b0, 20, acc);
            check_output("midload_accepted", int'(acc), 1);
         end
         do_reset(2);
      end
      prog_q = '{4'h5, 4'hC};
      run_program(1'b1, 1);

      // Random programs with random stalls.
      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(1, DEPTH);
         prog_q.delete();
         for (int i = 0; i < len; i++) prog_q.push_back(DATA_W'($urandom));
         run_program(1'b1, 3);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
